dac_spi_responder: RTL and testbench
====================================

Name: dac_spi_responder

Overview:
- SPI slave receiver for the 24-bit DAC write frames (SCK/CS/SDI/LDAC) that the DAC channels drive; it is the receiving end of that link.
- Decodes each frame into command/address/data, holds a DAC input register and an output register, and applies LDAC.
- Used on the board for loopback self-test of the DAC links and as the synthesizable DAC model in system benches.
- All inputs are asynchronous to `clock`. They are oversampled, so `clock` must be at least 4x SCK, with SCK high and low each lasting at least 2 clock periods.

Parameters:
FRAME_BITS, 24, bits per valid frame; MSB first
DATA_BITS, 16, data field width (frame bits [DATA_BITS-1:0])
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2)

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-high reset
spi_sck  input  1  serial clock; SDI is sampled on its rising edge
spi_cs_n  input  1  chip select, active low; frames one transfer
spi_sdi  input  1  serial data, MSB first
spi_ldac_n  input  1  load DAC, active low; acts on its falling edge
frame_valid  output  1  one-cycle pulse: a well-formed frame has been received
frame_cmd  output  4  frame bits [23:20]; held until the next valid frame
frame_addr  output  4  frame bits [19:16]; held until the next valid frame
frame_data  output  DATA_BITS  frame bits [15:0]; held until the next valid frame
frame_error  output  1  one-cycle pulse: CS rose with bit count != FRAME_BITS
dac_value  output  DATA_BITS  DAC output register
dac_update  output  1  one-cycle pulse: dac_value was loaded this cycle

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0, the input register goes to 0 and the state goes to IDLE.
  - Synchronizer flops reset to the idle levels (cs_n=1, sck=0, ldac_n=1) so that release from reset cannot create a false edge.
- Synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops, then one history flop.
  - An edge is detected in cycle E. All outputs are registered and become visible at E+1.
  - Latency from a pin edge to the output is at most SYNC_STAGES+2 clocks.
- State machine, IDLE:
  - On CS falling edge: clear the bit counter and shift register, go to RECV.
  - SCK edges are ignored.
  - A CS rising edge while in IDLE is ignored; it produces no error.
  - If reset is released while CS is already low, the block stays in IDLE until the next CS falling edge.
- State machine, RECV:
  - Each SCK rising edge shifts SDI into the LSB of a FRAME_BITS shift register.
  - The bit counter increments on each of those edges and saturates at FRAME_BITS+1.
  - On CS rising edge: go to IDLE and evaluate the frame.
- Frame evaluation when count == FRAME_BITS:
  - Load frame_cmd, frame_addr and frame_data; pulse frame_valid.
  - cmd 4'h0: load the input register with the data field.
  - cmd 4'h3: load the input register and dac_value with the data field; pulse dac_update.
  - Any other cmd: frame_valid only; neither register changes.
- Frame evaluation when count != FRAME_BITS (covers 0 bits, short frames and long frames):
  - Pulse frame_error.
  - frame_* outputs, the input register and dac_value are all unchanged.
- LDAC: on a spi_ldac_n falling edge, in any state, dac_value <= input register and dac_update pulses.
- Simultaneous events, when frame evaluation and an LDAC falling edge are detected in the same cycle:
  - cmd 0 or cmd 3: dac_value takes the new frame's data; the input register also takes it; one dac_update pulse.
  - Any other cmd, or an error frame: dac_value takes the existing input register.
- Short pulses: an SCK or CS pulse shorter than 2 clocks may be missed; it must not corrupt state beyond the frame in flight.
- Mid-frame reset: the partial frame is discarded, no pulses are produced, and the block waits for a fresh CS falling edge.

Test Plan:
- Send frame 0x03ABCD (cmd 0, addr 3, data 0xABCD).
  -> frame_valid pulses once; frame_cmd=0, frame_addr=3, frame_data=0xABCD; dac_value stays 0.
  - Then pulse LDAC low. -> dac_value=0xABCD; dac_update pulses once.
- Send frame 0x311234.
  -> frame_valid and dac_update pulse in the same cycle; dac_value=0x1234 with no LDAC.
  - Then send 0x7F5555. -> frame_valid pulses; frame_cmd=7; dac_value stays 0x1234.
- After frame 0x030001, send a 23-bit frame, then a 25-bit frame, then CS low/high with 0 SCK edges.
  -> three frame_error pulses; no frame_valid; frame_data stays 0x0001.
  - Then LDAC. -> dac_value=0x0001.
- Assert reset after 10 bits of 0x03BEEF.
  -> all outputs 0.
  - Release reset with CS still low and finish clocking the bits, then raise CS. -> no pulse of any kind.
  - Next full frame 0x32CAFE. -> dac_value=0xCAFE.
- Input register holds 0x1111. Complete frame 0x032222 and take LDAC low so both are detected in the same cycle.
  -> dac_value=0x2222; one dac_update pulse.
  - Repeat with frame 0x5F3333. -> dac_value=0x1111 (the held input register).
- Clock running at exactly 4x SCK, with pin edges aligned to random phases of `clock`.
  -> 100 random cmd-0/cmd-3 frames give bit-exact frame_data and dac_value with zero frame_error.

Source files
------------

// File: rtl/dac_spi_responder.sv
// SPI slave receiver for 24-bit DAC write frames: oversamples SCK/CS/SDI/LDAC,
// decodes command/address/data and maintains the DAC input and output registers.
`timescale 1ns/1ps

module dac_spi_responder #(
    parameter int unsigned FRAME_BITS  = 24,
    parameter int unsigned DATA_BITS   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 spi_sck,
    input  logic                 spi_cs_n,
    input  logic                 spi_sdi,
    input  logic                 spi_ldac_n,
    output logic                 frame_valid,
    output logic [3:0]           frame_cmd,
    output logic [3:0]           frame_addr,
    output logic [DATA_BITS-1:0] frame_data,
    output logic                 frame_error,
    output logic [DATA_BITS-1:0] dac_value,
    output logic                 dac_update
);

    localparam int unsigned CNT_W   = $clog2(FRAME_BITS + 2);
    localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(FRAME_BITS + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(SYNC_STAGES + 1);
    localparam logic [3:0] CMD_WRITE_INPUT  = 4'h0;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] ldac_sync;
    logic                   sck_hist;
    logic                   cs_hist;
    logic                   ldac_hist;
    logic [FLUSH_W-1:0]     flush_cnt;

    // Input synchronizers plus one history flop each for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            sdi_sync  <= '0;
            ldac_sync <= '1;
            sck_hist  <= 1'b0;
            cs_hist   <= 1'b1;
            ldac_hist <= 1'b1;
            flush_cnt <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            ldac_sync <= {ldac_sync[SYNC_STAGES-2:0], spi_ldac_n};
            sck_hist  <= sck_sync[SYNC_STAGES-1];
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            ldac_hist <= ldac_sync[SYNC_STAGES-1];
            if (flush_cnt != FLUSH_END) begin
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            end
        end
    end

    // Edges are masked until the pipeline holds real pin levels, so a pin
    // already low at reset release (CS or LDAC) never looks like a falling edge.
    logic sync_ready;
    logic sck_s;
    logic cs_s;
    logic sdi_s;
    logic ldac_s;
    logic sck_rise;
    logic cs_fall;
    logic cs_rise;
    logic ldac_fall;

    assign sync_ready = (flush_cnt == FLUSH_END);
    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign sdi_s      = sdi_sync[SYNC_STAGES-1];
    assign ldac_s     = ldac_sync[SYNC_STAGES-1];
    assign sck_rise   = sync_ready &  sck_s  & ~sck_hist;
    assign cs_fall    = sync_ready & ~cs_s   &  cs_hist;
    assign cs_rise    = sync_ready &  cs_s   & ~cs_hist;
    assign ldac_fall  = sync_ready & ~ldac_s &  ldac_hist;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       bit_cnt_nxt;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [FRAME_BITS-1:0]  shift_nxt;
    logic [DATA_BITS-1:0]   input_reg;
    logic [DATA_BITS-1:0]   input_nxt;
    logic                   valid_nxt;
    logic                   error_nxt;
    logic                   update_nxt;
    logic [3:0]             cmd_nxt;
    logic [3:0]             addr_nxt;
    logic [DATA_BITS-1:0]   data_nxt;
    logic [DATA_BITS-1:0]   dac_nxt;

    logic [3:0]             rx_cmd;
    logic [3:0]             rx_addr;
    logic [DATA_BITS-1:0]   rx_data;

    assign rx_cmd  = shift_reg[FRAME_BITS-1 -: 4];
    assign rx_addr = shift_reg[FRAME_BITS-5 -: 4];
    assign rx_data = shift_reg[DATA_BITS-1:0];

    // Next-state and output logic
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        input_nxt   = input_reg;
        valid_nxt   = 1'b0;
        error_nxt   = 1'b0;
        update_nxt  = 1'b0;
        cmd_nxt     = frame_cmd;
        addr_nxt    = frame_addr;
        data_nxt    = frame_data;
        dac_nxt     = dac_value;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    bit_cnt_nxt = '0;
                    shift_nxt   = '0;
                    state_nxt   = RECV;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    if (bit_cnt == CNT_FULL) begin
                        valid_nxt = 1'b1;
                        cmd_nxt   = rx_cmd;
                        addr_nxt  = rx_addr;
                        data_nxt  = rx_data;
                        if (rx_cmd == CMD_WRITE_INPUT) begin
                            input_nxt = rx_data;
                        end else if (rx_cmd == CMD_WRITE_UPDATE) begin
                            input_nxt  = rx_data;
                            dac_nxt    = rx_data;
                            update_nxt = 1'b1;
                        end
                    end else begin
                        error_nxt = 1'b1;
                    end
                end else if (cs_fall) begin
                    // A missed CS rise: restart on the new frame
                    bit_cnt_nxt = '0;
                    shift_nxt   = '0;
                end else if (sck_rise) begin
                    shift_nxt = {shift_reg[FRAME_BITS-2:0], sdi_s};
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // LDAC sees the input register as updated by a coincident frame
        if (ldac_fall) begin
            dac_nxt    = input_nxt;
            update_nxt = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            input_reg   <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            dac_update  <= 1'b0;
            frame_cmd   <= '0;
            frame_addr  <= '0;
            frame_data  <= '0;
            dac_value   <= '0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift_reg   <= shift_nxt;
            input_reg   <= input_nxt;
            frame_valid <= valid_nxt;
            frame_error <= error_nxt;
            dac_update  <= update_nxt;
            frame_cmd   <= cmd_nxt;
            frame_addr  <= addr_nxt;
            frame_data  <= data_nxt;
            dac_value   <= dac_nxt;
        end
    end

endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed and random-phase bench for dac_spi_responder: drives SPI frames and
// LDAC pulses at 4x oversampling and checks decoded fields, pulses and DAC value.
`timescale 1ns/1ps

module tb_dac_spi_responder;

    localparam int unsigned DATA_BITS = 16;
    localparam int HALF = 20;

    logic                 clock;
    logic                 reset;
    logic                 spi_sck;
    logic                 spi_cs_n;
    logic                 spi_sdi;
    logic                 spi_ldac_n;
    logic                 frame_valid;
    logic [3:0]           frame_cmd;
    logic [3:0]           frame_addr;
    logic [DATA_BITS-1:0] frame_data;
    logic                 frame_error;
    logic [DATA_BITS-1:0] dac_value;
    logic                 dac_update;

    dac_spi_responder #(
        .FRAME_BITS (24),
        .DATA_BITS  (DATA_BITS),
        .SYNC_STAGES(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_sdi    (spi_sdi),
        .spi_ldac_n (spi_ldac_n),
        .frame_valid(frame_valid),
        .frame_cmd  (frame_cmd),
        .frame_addr (frame_addr),
        .frame_data (frame_data),
        .frame_error(frame_error),
        .dac_value  (dac_value),
        .dac_update (dac_update)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_upd = 0;
    int n_both = 0;
    int v0, e0, u0, b0;

    // Pulse counters sampled mid-cycle
    always @(negedge clock) begin
        if (frame_valid) n_valid++;
        if (frame_error) n_err++;
        if (dac_update) n_upd++;
        if (frame_valid && dac_update) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        v0 = n_valid;
        e0 = n_err;
        u0 = n_upd;
        b0 = n_both;
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic clock_bits(input logic [31:0] value, input int nbits, input int first, input int last);
        for (int i = first; i < last; i++) begin
            spi_sdi = value[nbits-1-i];
            #HALF spi_sck = 1'b1;
            #HALF spi_sck = 1'b0;
        end
    endtask

    task automatic cs_high(input bit with_ldac);
        #HALF;
        spi_cs_n = 1'b1;
        if (with_ldac) spi_ldac_n = 1'b0;
        #(2*HALF);
        spi_ldac_n = 1'b1;
        #100;
    endtask

    task automatic send(input logic [31:0] value, input int nbits, input bit with_ldac);
        cs_low();
        clock_bits(value, nbits, 0, nbits);
        cs_high(with_ldac);
    endtask

    task automatic ldac_pulse();
        spi_ldac_n = 1'b0;
        #40;
        spi_ldac_n = 1'b1;
        #100;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out"}, {frame_valid, frame_error, dac_update, frame_cmd, frame_addr}, 32'h0);
        check({tag, "_data"}, 32'(frame_data), 32'h0);
        check({tag, "_dac"}, 32'(dac_value), 32'h0);
    endtask

    logic [15:0] model_dac;
    logic [23:0] frm;
    logic [3:0]  rcmd;

    initial begin
        reset = 1'b1;
        spi_sck = 1'b0;
        spi_cs_n = 1'b1;
        spi_sdi = 1'b0;
        spi_ldac_n = 1'b1;
        #28;
        check_outputs_zero("reset");
        reset = 1'b0;
        #100;

        // cmd 0 writes the input register only; LDAC then transfers it
        snap();
        send(32'h03ABCD, 24, 1'b0);
        check("f1_valid", 32'(n_valid - v0), 32'd1);
        check("f1_cmd", 32'(frame_cmd), 32'h0);
        check("f1_addr", 32'(frame_addr), 32'h3);
        check("f1_data", 32'(frame_data), 32'hABCD);
        check("f1_dac", 32'(dac_value), 32'h0);
        check("f1_upd", 32'(n_upd - u0), 32'd0);
        snap();
        ldac_pulse();
        check("ldac1_dac", 32'(dac_value), 32'hABCD);
        check("ldac1_upd", 32'(n_upd - u0), 32'd1);

        // cmd 3 updates directly; unknown cmd leaves registers alone
        snap();
        send(32'h311234, 24, 1'b0);
        check("f2_both", 32'(n_both - b0), 32'd1);
        check("f2_dac", 32'(dac_value), 32'h1234);
        check("f2_addr", 32'(frame_addr), 32'h1);
        snap();
        send(32'h7F5555, 24, 1'b0);
        check("f3_valid", 32'(n_valid - v0), 32'd1);
        check("f3_cmd", 32'(frame_cmd), 32'h7);
        check("f3_dac", 32'(dac_value), 32'h1234);
        check("f3_upd", 32'(n_upd - u0), 32'd0);

        // Short, long and empty frames
        send(32'h030001, 24, 1'b0);
        snap();
        send(32'h2AAAAA, 23, 1'b0);
        send(32'h1555555, 25, 1'b0);
        send(32'h0, 0, 1'b0);
        check("err_count", 32'(n_err - e0), 32'd3);
        check("err_valid", 32'(n_valid - v0), 32'd0);
        check("err_data", 32'(frame_data), 32'h0001);
        ldac_pulse();
        check("err_ldac_dac", 32'(dac_value), 32'h0001);

        // Mid-frame reset, released with CS still low
        cs_low();
        clock_bits(32'h03BEEF, 24, 0, 10);
        reset = 1'b1;
        #20;
        check_outputs_zero("midrst");
        reset = 1'b0;
        #60;
        snap();
        clock_bits(32'h03BEEF, 24, 10, 24);
        cs_high(1'b0);
        check("midrst_pulses", 32'(n_valid - v0 + n_err - e0 + n_upd - u0), 32'd0);
        check("midrst_data", 32'(frame_data), 32'h0);
        snap();
        send(32'h32CAFE, 24, 1'b0);
        check("after_rst_dac", 32'(dac_value), 32'hCAFE);
        check("after_rst_upd", 32'(n_upd - u0), 32'd1);

        // Frame end and LDAC detected in the same cycle
        send(32'h031111, 24, 1'b0);
        check("sim_pre_dac", 32'(dac_value), 32'hCAFE);
        snap();
        send(32'h032222, 24, 1'b1);
        check("sim0_dac", 32'(dac_value), 32'h2222);
        check("sim0_upd", 32'(n_upd - u0), 32'd1);
        send(32'h031111, 24, 1'b0);
        snap();
        send(32'h5F3333, 24, 1'b1);
        check("sim5_dac", 32'(dac_value), 32'h1111);
        check("sim5_upd", 32'(n_upd - u0), 32'd1);
        check("sim5_cmd", 32'(frame_cmd), 32'h5);
        check("sim5_data", 32'(frame_data), 32'h3333);

        // Random frames at random clock phases
        model_dac = 16'h1111;
        snap();
        for (int k = 0; k < 100; k++) begin
            @(posedge clock);
            #($urandom_range(1, 9));
            rcmd = ($urandom_range(0, 1) == 1) ? 4'h3 : 4'h0;
            frm = {rcmd, 4'($urandom_range(0, 15)), 16'($urandom)};
            if (rcmd == 4'h3) model_dac = frm[15:0];
            send(32'(frm), 24, 1'b0);
            check("rnd_data", 32'(frame_data), 32'(frm[15:0]));
            check("rnd_dac", 32'(dac_value), 32'(model_dac));
        end
        check("rnd_err", 32'(n_err - e0), 32'd0);
        check("rnd_valid", 32'(n_valid - v0), 32'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
